// File: rtl/mod_mul_radix.sv
// Interleaved modular multiplier: S = (A*B) mod N.
// A is consumed MSB first, K bits per clock, with K radix-2 reduction steps unrolled per cycle.
// Uses an enable/finish level handshake: enable is held high until finish is seen, then dropped.
module mod_mul_radix #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned K     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] S,
  output logic             finish,
  output logic             err,
  output logic             busy
);

  localparam int unsigned ITER = WIDTH / K;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_next;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH+1:0] acc;
  logic             operands_bad;

  // Operands that would break the R < N invariant are rejected at accept time.
  assign operands_bad = (N == '0) || (B >= N);

  // K unrolled radix-2 steps on the top K bits of the shifted multiplier copy.
  // R < N on entry, so 2R + B < 3N fits in WIDTH+2 bits and two subtracts restore R < N.
  always_comb begin
    acc = {2'b00, r_q};
    for (int j = 0; j < int'(K); j++) begin
      acc = {acc[WIDTH:0], 1'b0} + (a_q[WIDTH-1-j] ? {2'b00, b_q} : '0);
      if (acc >= {2'b00, n_q}) acc = acc - {2'b00, n_q};
      if (acc >= {2'b00, n_q}) acc = acc - {2'b00, n_q};
    end
    r_next = acc[WIDTH-1:0];
  end

  // Control FSM with registered handshake outputs and the datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      S       <= '0;
      finish  <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            a_q   <= A;
            b_q   <= B;
            n_q   <= N;
            r_q   <= '0;
            cnt_q <= '0;
            if (operands_bad) begin
              state_q <= StDone;
              S       <= '0;
              err     <= 1'b1;
              finish  <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_q <= StCalc;
              busy    <= 1'b1;
              err     <= 1'b0;
            end
          end
        end
        StCalc: begin
          if (!enable) begin
            // Abort: drop the partial result, S keeps the previous answer.
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            r_q   <= r_next;
            a_q   <= a_q << K;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              S       <= r_next;
              finish  <= 1'b1;
              busy    <= 1'b0;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (!enable) begin
            finish  <= 1'b0;
            err     <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_radix.sv
// Self-checking bench for mod_mul_radix: four instances (8-bit K=2/K=8, 256-bit K=1/K=4),
// table vectors, randomized operands against a big-integer reference, abort and reset cases.
module tb_mod_mul_radix;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   en;
  logic [7:0]   a8, b8, n8;
  logic [255:0] a256, b256, n256;
  logic [7:0]   s8_k2, s8_k8;
  logic [255:0] s_k1, s_k4;
  logic [3:0]   fin, er, bz;
  logic [255:0] s_all [4];

  assign s_all[0] = {248'd0, s8_k2};
  assign s_all[1] = {248'd0, s8_k8};
  assign s_all[2] = s_k1;
  assign s_all[3] = s_k4;

  mod_mul_radix #(.WIDTH(8), .K(2)) u_k2 (
    .clk(clk), .rst(rst), .enable(en[0]), .A(a8), .B(b8), .N(n8),
    .S(s8_k2), .finish(fin[0]), .err(er[0]), .busy(bz[0])
  );
  mod_mul_radix #(.WIDTH(8), .K(8)) u_k8 (
    .clk(clk), .rst(rst), .enable(en[1]), .A(a8), .B(b8), .N(n8),
    .S(s8_k8), .finish(fin[1]), .err(er[1]), .busy(bz[1])
  );
  mod_mul_radix #(.WIDTH(256), .K(1)) u_k1 (
    .clk(clk), .rst(rst), .enable(en[2]), .A(a256), .B(b256), .N(n256),
    .S(s_k1), .finish(fin[2]), .err(er[2]), .busy(bz[2])
  );
  mod_mul_radix #(.WIDTH(256), .K(4)) u_k4 (
    .clk(clk), .rst(rst), .enable(en[3]), .A(a256), .B(b256), .N(n256),
    .S(s_k4), .finish(fin[3]), .err(er[3]), .busy(bz[3])
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [255:0] last_exp [4];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] n;
    logic [7:0] s;
    logic       e;
  } vec_t;
  vec_t tbl [10];

  logic [255:0] va, vb, vn, ve;
  logic         verr;
  bit           seen;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: plain wide integer multiply then modulo.
  function automatic logic [255:0] ref_mod(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] n);
    logic [511:0] p;
    p = {256'd0, a} * {256'd0, b};
    p = p % {256'd0, n};
    return p[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int iter_of(input int idx);
    case (idx)
      0: return 4;
      1: return 1;
      2: return 256;
      default: return 64;
    endcase
  endfunction

  // One full request/finish/release handshake on instance idx.
  task automatic run_op(input int idx, input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] n, input logic [255:0] exp_s, input logic exp_err,
                        input string tag);
    int lat;
    int busy_cnt;
    bit got;
    int exp_lat;
    lat = 0;
    busy_cnt = 0;
    got = 0;
    exp_lat = exp_err ? 1 : iter_of(idx) + 1;
    @(negedge clk);
    if (idx < 2) begin
      a8 = a[7:0]; b8 = b[7:0]; n8 = n[7:0];
    end else begin
      a256 = a; b256 = b; n256 = n;
    end
    en[idx] = 1'b1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk); #1;
      lat++;
      if (bz[idx]) busy_cnt++;
      if (fin[idx]) got = 1;
      if (c == 0) begin
        // Operand changes after accept must not matter.
        a8 = 8'($urandom()); b8 = 8'($urandom()); n8 = 8'($urandom());
        a256 = rand256(); b256 = rand256(); n256 = rand256();
      end
    end
    check1($sformatf("%s finish", tag), 1'(got), 1'b1);
    if (got) begin
      check($sformatf("%s S", tag), s_all[idx], exp_s);
      check1($sformatf("%s err", tag), er[idx], exp_err);
      check($sformatf("%s latency", tag), 256'(lat), 256'(exp_lat));
      check($sformatf("%s busy cycles", tag), 256'(busy_cnt),
            256'(exp_err ? 0 : iter_of(idx)));
      @(posedge clk); #1;
      check1($sformatf("%s finish held", tag), fin[idx], 1'b1);
      check($sformatf("%s S held", tag), s_all[idx], exp_s);
    end
    @(negedge clk);
    en[idx] = 1'b0;
    @(posedge clk); #1;
    check1($sformatf("%s finish drop", tag), fin[idx], 1'b0);
    check1($sformatf("%s err drop", tag), er[idx], 1'b0);
    check($sformatf("%s S after drop", tag), s_all[idx], exp_s);
    last_exp[idx] = exp_s;
  endtask

  initial begin
    en = '0;
    a8 = '0; b8 = '0; n8 = '0;
    a256 = '0; b256 = '0; n256 = '0;
    for (int i = 0; i < 4; i++) last_exp[i] = '0;

    tbl[0] = '{8'd5,   8'd7,   8'd11,  8'd2,  1'b0};
    tbl[1] = '{8'd3,   8'd4,   8'd5,   8'd2,  1'b0};
    tbl[2] = '{8'd0,   8'd7,   8'd11,  8'd0,  1'b0};
    tbl[3] = '{8'd255, 8'd10,  8'd11,  8'd9,  1'b0};
    tbl[4] = '{8'd200, 8'd254, 8'd255, 8'd55, 1'b0};
    tbl[5] = '{8'd7,   8'd11,  8'd11,  8'd0,  1'b1};
    tbl[6] = '{8'd7,   8'd0,   8'd0,   8'd0,  1'b1};
    tbl[7] = '{8'd9,   8'd12,  8'd11,  8'd0,  1'b1};
    tbl[8] = '{8'd1,   8'd0,   8'd1,   8'd0,  1'b0};
    tbl[9] = '{8'd255, 8'd254, 8'd255, 8'd0,  1'b0};

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset S[%0d]", i), s_all[i], 256'd0);
      check1($sformatf("reset finish[%0d]", i), fin[i], 1'b0);
      check1($sformatf("reset err[%0d]", i), er[i], 1'b0);
      check1($sformatf("reset busy[%0d]", i), bz[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table vectors on both 8-bit instances.
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 2; d++) begin
        run_op(d, 256'(tbl[i].a), 256'(tbl[i].b), 256'(tbl[i].n), 256'(tbl[i].s), tbl[i].e,
               $sformatf("tbl%0d/u%0d", i, d));
      end
    end

    // Random 8-bit vectors, mostly valid, back-to-back.
    for (int i = 0; i < 240; i++) begin
      vn = 256'($urandom_range(0, 255));
      vb = 256'($urandom_range(0, 255));
      va = 256'($urandom_range(0, 255));
      if (vn != 0 && $urandom_range(0, 4) != 0) vb = vb % vn;
      verr = (vn == 0) || (vb >= vn);
      ve = verr ? 256'd0 : ref_mod(va, vb, vn);
      run_op(i % 2, va, vb, vn, ve, verr, $sformatf("rnd8_%0d", i));
    end

    // 256-bit: A = B = N-1 gives 1; then random operands; one rejected case.
    for (int d = 2; d < 4; d++) begin
      vn = rand256() | 256'd1 | {1'b1, 255'd0};
      run_op(d, vn - 1, vn - 1, vn, 256'd1, 1'b0, $sformatf("nm1_u%0d", d));
      for (int i = 0; i < (d == 2 ? 3 : 8); i++) begin
        vn = rand256() | 256'd1;
        va = rand256();
        vb = rand256() % vn;
        run_op(d, va, vb, vn, ref_mod(va, vb, vn), 1'b0, $sformatf("rnd256_u%0d_%0d", d, i));
      end
      vn = rand256() | 256'd1;
      run_op(d, rand256(), vn, vn, 256'd0, 1'b1, $sformatf("bad256_u%0d", d));
      vn = rand256() | 256'd1;
      va = rand256();
      vb = rand256() % vn;
      run_op(d, va, vb, vn, ref_mod(va, vb, vn), 1'b0, $sformatf("post_bad_u%0d", d));
    end

    // Abort 10 cycles into CALC on the K=4 instance.
    @(negedge clk);
    a256 = rand256();
    n256 = rand256() | 256'd1;
    b256 = rand256() % n256;
    en[3] = 1'b1;
    @(posedge clk); #1;
    check1("abort busy on accept", bz[3], 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    en[3] = 1'b0;
    @(posedge clk); #1;
    check1("abort busy", bz[3], 1'b0);
    check1("abort finish", fin[3], 1'b0);
    check("abort S held", s_all[3], last_exp[3]);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (fin[3]) seen = 1;
    end
    check1("abort no finish", 1'(seen), 1'b0);
    vn = rand256() | 256'd1;
    va = rand256();
    vb = rand256() % vn;
    run_op(3, va, vb, vn, ref_mod(va, vb, vn), 1'b0, "after_abort");

    // Asynchronous reset between edges mid-CALC.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; n8 = 8'd201;
    en[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check1("pre-reset busy", bz[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid-reset S", s_all[0], 256'd0);
    check1("mid-reset finish", fin[0], 1'b0);
    check1("mid-reset busy", bz[0], 1'b0);
    check1("mid-reset err", er[0], 1'b0);
    check("mid-reset S k4", s_all[3], 256'd0);
    @(negedge clk);
    rst = 1'b0;
    en[0] = 1'b0;
    for (int i = 0; i < 4; i++) last_exp[i] = '0;
    run_op(0, 256'd3, 256'd4, 256'd5, 256'd2, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
